// File: rtl/relay_sequencer.sv
// One-hot sequencer pulse generator for the LED/control bus: free-run, single-step,
// halt at end of instruction and restart, with a per-instruction cycle length.
module relay_sequencer #(
  parameter int FSM_W      = 19,
  parameter int MIN_LEN    = 8,
  parameter int LEN_SAMPLE = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             restart,
  input  logic [4:0]       len,
  output logic [FSM_W-1:0] fsm_out,
  output logic             cycle_start,
  output logic             cycle_done,
  output logic             halted
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HALTED} st_t;

  localparam logic [4:0]       FSM_W5    = 5'(FSM_W);
  localparam logic [4:0]       MIN5      = 5'(MIN_LEN);
  localparam logic [4:0]       SAMPLE5   = 5'(LEN_SAMPLE);
  localparam logic [4:0]       TOP5      = 5'(FSM_W - 1);
  localparam logic [FSM_W-1:0] PULSE_LSB = {{(FSM_W-1){1'b0}}, 1'b1};

  st_t        st, st_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic [4:0] len_q, len_nxt;
  logic       halt_q, halt_nxt;
  logic       step_d;
  logic       advance;
  logic [4:0] last;
  logic       done;

  function automatic logic [4:0] clamp_len(input logic [4:0] l);
    if (l < MIN5)        return MIN5;
    else if (l > FSM_W5) return FSM_W5;
    else                 return l;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st     <= IDLE;
      cnt    <= 5'd0;
      len_q  <= FSM_W5;
      halt_q <= 1'b0;
      step_d <= 1'b0;
    end else begin
      st     <= st_nxt;
      cnt    <= cnt_nxt;
      len_q  <= len_nxt;
      halt_q <= halt_nxt;
      step_d <= step;
    end
  end

  // At the sample state the freshly clamped length decides the end, so an
  // 8-state instruction finishes on the very state that latches its length.
  always_comb begin
    advance  = run | (step & ~step_d);
    last     = (cnt == SAMPLE5) ? (clamp_len(len) - 5'd1) : (len_q - 5'd1);
    st_nxt   = st;
    cnt_nxt  = cnt;
    len_nxt  = len_q;
    halt_nxt = halt_q;
    done     = 1'b0;
    case (st)
      IDLE: begin
        if (advance) begin
          st_nxt  = ACTIVE;
          cnt_nxt = 5'd0;
        end
      end
      ACTIVE: begin
        if (cnt == 5'd0) len_nxt = FSM_W5;
        if (halt_req)    halt_nxt = 1'b1;
        if (advance) begin
          if (cnt == SAMPLE5) len_nxt = clamp_len(len);
          if (cnt == last) begin
            done    = 1'b1;
            cnt_nxt = 5'd0;
            if (halt_q || halt_req) begin
              st_nxt   = HALTED;
              halt_nxt = 1'b0;
            end
          end else begin
            cnt_nxt = cnt + 5'd1;
          end
        end
      end
      HALTED: begin
        st_nxt = HALTED;
      end
      default: begin
        st_nxt  = IDLE;
        cnt_nxt = 5'd0;
      end
    endcase
    // Restart wins over any advance or halt request in the same clock.
    if (restart) begin
      st_nxt   = IDLE;
      cnt_nxt  = 5'd0;
      halt_nxt = 1'b0;
      done     = 1'b0;
    end
  end

  always_comb begin
    fsm_out     = (st == ACTIVE) ? (PULSE_LSB << (TOP5 - cnt)) : '0;
    cycle_start = (st == ACTIVE) && (cnt == 5'd0);
    cycle_done  = done;
    halted      = (st == HALTED);
  end

endmodule

// File: tb/tb_relay_sequencer.sv
// Directed bench for relay_sequencer: expected output vectors are queued per
// clock by the stimulus and checked by an independent monitor on the falling edge.
module tb_relay_sequencer;

  logic        clk;
  logic        reset_n;
  logic        run, step, halt_req, restart;
  logic [4:0]  len;
  logic [18:0] fsm_out;
  logic        cycle_start, cycle_done, halted;

  typedef struct {
    string       name;
    logic [21:0] v;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [21:0] IDLE_E = 22'h0;
  localparam logic [21:0] HALT_E = 22'h1;

  relay_sequencer #(.FSM_W(19), .MIN_LEN(8), .LEN_SAMPLE(7)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .step(step), .halt_req(halt_req),
    .restart(restart), .len(len), .fsm_out(fsm_out), .cycle_start(cycle_start),
    .cycle_done(cycle_done), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {fsm_out, cycle_start, cycle_done, halted} for state k of a cycle.
  function automatic logic [21:0] act(input int k, input logic d);
    logic [18:0] p;
    p = 19'h40000;
    p = p >> k;
    return {p, (k == 0), d, 1'b0};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [21:0] got;
    if (q.size() > 0) begin
      e   = q.pop_front();
      got = {fsm_out, cycle_start, cycle_done, halted};
      n_cmp++;
      if (got !== e.v) begin
        n_bad++;
        $display("FAIL %s: got fsm_out=%h cs=%b cd=%b h=%b, want fsm_out=%h cs=%b cd=%b h=%b",
                 e.name, got[21:3], got[2], got[1], got[0], e.v[21:3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  task automatic cyc(input string nm, input logic r, input logic s, input logic h,
                     input logic rs, input logic [4:0] l, input logic [21:0] ev);
    exp_t e;
    run      = r;
    step     = s;
    halt_req = h;
    restart  = rs;
    len      = l;
    e.name   = nm;
    e.v      = ev;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0; restart = 1'b0; len = 5'd8;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, IDLE_E);
    reset_n = 1'b1;

    // Free-run, len 8, two back-to-back cycles
    cyc("t2_idle", 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, IDLE_E);
    for (int rep = 0; rep < 2; rep++)
      for (int k = 0; k < 8; k++)
        cyc($sformatf("t2_r%0d_k%0d", rep, k), 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, act(k, k == 7));

    // Length latched at state 7 only
    for (int k = 0; k < 12; k++)
      cyc($sformatf("t3_len12_k%0d", k), 1'b1, 1'b0, 1'b0, 1'b0,
          (k <= 7) ? 5'd12 : 5'd8, act(k, k == 11));
    for (int k = 0; k < 8; k++)
      cyc($sformatf("t3_len3_k%0d", k), 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, act(k, k == 7));
    for (int k = 0; k < 19; k++)
      cyc($sformatf("t3_len25_k%0d", k), 1'b1, 1'b0, 1'b0, 1'b0, 5'd25, act(k, k == 18));

    // Halt request at state 2 of a 10-state cycle
    for (int k = 0; k < 10; k++)
      cyc($sformatf("t5_k%0d", k), 1'b1, 1'b0, (k == 2), 1'b0, 5'd10, act(k, k == 9));
    for (int k = 0; k < 3; k++)
      cyc($sformatf("t5_halted_%0d", k), 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, HALT_E);

    // Restart out of HALTED, then resume
    cyc("t6_restart_in_halt", 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, HALT_E);
    cyc("t6_idle_after_restart", 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, IDLE_E);
    for (int k = 0; k < 7; k++)
      cyc($sformatf("t6_resume_k%0d", k), 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, act(k, 1'b0));
    // Restart coincident with cycle-end advance and halt request
    cyc("t6_restart_at_end", 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, act(7, 1'b0));
    cyc("t6_idle_0", 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, IDLE_E);
    cyc("t6_idle_1", 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, IDLE_E);

    // Single-step: held step gives one advance, then two more pulses
    cyc("t4_step_rise", 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, IDLE_E);
    for (int k = 0; k < 4; k++)
      cyc($sformatf("t4_held_%0d", k), 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, act(0, 1'b0));
    cyc("t4_low_0", 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, act(0, 1'b0));
    cyc("t4_pulse_1", 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, act(0, 1'b0));
    cyc("t4_low_1", 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, act(1, 1'b0));
    cyc("t4_pulse_2", 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, act(1, 1'b0));
    cyc("t4_low_2", 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, act(2, 1'b0));

    // Asynchronous reset in the middle of a cycle at state 5
    cyc("t1_k2", 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, act(2, 1'b0));
    cyc("t1_k3", 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, act(3, 1'b0));
    cyc("t1_k4", 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, act(4, 1'b0));
    reset_n = 1'b0;
    cyc("t1_reset_mid", 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, IDLE_E);
    cyc("t1_reset_hold", 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, IDLE_E);
    reset_n = 1'b1;
    cyc("t1_release", 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, IDLE_E);
    for (int k = 0; k < 8; k++)
      cyc($sformatf("t1_after_k%0d", k), 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, act(k, k == 7));

    @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL queue_drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
